bcd_push_ctrl: RTL and testbench
================================

# bcd_push_ctrl

Front-end controller that sequences the 3-digit BCD up/down counter from the two active-low push buttons. Synchronises and debounces `Push[1:0]` and arbitrates between the up and down buttons. Converts presses into single-cycle `Inc`/`Dec` commands, with auto-repeat while a button is held. Sits between the board buttons and the counter datapath, replacing direct button-to-counter wiring.

## Interface
- `DEB_CYC`, default 4: cycles a synchronised level must stay stable to qualify a press or a release.
- `HOLD_CYC`, default 16: cycles from the first command to the first auto-repeat command.
- `REP_CYC`, default 8: cycles between successive auto-repeat commands.
- `CW`, default 8: width of the shared internal timer; must hold max(`DEB_CYC`, `HOLD_CYC`, `REP_CYC`).

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: reset; asynchronous and active-low.
- `Push`, in, 2: raw buttons, active-low. `Push[1]` is UP and `Push[0]` is DOWN. Idle value is 2'b11.
- `Inc`, out, 1: one-cycle increment command to the counter.
- `Dec`, out, 1: one-cycle decrement command to the counter.
- `Rep`, out, 1: high while auto-repeat is active.
- `State`, out, 3: current FSM state encoding, for debug and LED display.

## Operation
- `Push` passes through a 2-FF synchroniser to produce `sp[1:0]`. All decisions use `sp`.
- FSM states: IDLE, QUAL, FIRE, HOLD, REPEAT, REL.
- **IDLE**
  - Exactly one `sp` bit low: latch the direction (UP/DOWN), clear the timer, go to QUAL.
  - `sp` = 2'b00: go to REL with no command.
- **QUAL**
  - The latched bit must stay low for `DEB_CYC` consecutive cycles, then go to FIRE.
  - Latched bit returns high: back to IDLE (glitch rejected).
  - Other bit goes low: go to REL with no command.
- **FIRE**
  - One cycle only. `Inc` is high if direction is UP, `Dec` is high if DOWN. Clear the timer and go to HOLD.
- **HOLD**
  - Count `HOLD_CYC` cycles. If the button is still low, pulse the command and go to REPEAT.
  - Latched bit high: go to REL.
- **REPEAT**
  - Pulse the command every `REP_CYC` cycles. `Rep` is 1 in this state.
  - Latched bit high: go to REL.
- **REL**
  - Wait until `sp` = 2'b11 holds for `DEB_CYC` consecutive cycles, then go to IDLE.
  - Any low `sp` bit restarts the count.
- Only one command per cycle. `Inc` and `Dec` are never high together.
- Any button pressed while the other is latched is ignored until REL completes.
- The timer saturates and never wraps. Width rules follow `CW`.

## Timing
- Reset values: `Inc`=0, `Dec`=0, `Rep`=0, `State`=IDLE. Synchroniser flops reset to 1 and the timer resets to 0.
- Reset asserted mid-operation clears everything immediately; no command is issued afterwards.
- Press latency: number edge 1 as the first rising edge that samples `Push` low. The first command is high in the cycle after edge `DEB_CYC`+3.
- First repeat comes `HOLD_CYC` cycles after the first command; later repeats are spaced `REP_CYC` cycles apart.
- Release latency: `sp` sees the release 2 edges after `Push` rises. No command can be issued after `sp` goes high.
- Outputs are registered, with no combinational path from `Push`.

## Structure
- Package `bcd_ctrl_pkg` holds:
  - the state encoding type (3-bit) with the six state constants;
  - the direction constants `DIR_UP`/`DIR_DN`;
  - the button index constants `BTN_UP`=1 and `BTN_DN`=0.
- Sub-module `btn_sync`: parameterised-width 2-FF synchroniser with reset value 1, instantiated once for `Push[1:0]`.
- Top level holds the FSM, the shared `CW`-bit timer and the direction flop.

## Test plan
Defaults apply and the clock period is 20 ns.
- **Reset:** hold `Rst`=0 for 3 cycles with `Push`=2'b01, then release with `Push`=2'b11. Expect `Inc`=`Dec`=`Rep`=0 and `State`=IDLE, with no pulse. Re-asserting `Rst` during REPEAT returns to IDLE in the same cycle.
- **Single press:** `Push`=2'b01 for 10 cycles, then 2'b11. Expect exactly one `Inc` pulse, in the cycle after edge 7, and `Dec` never high. Repeat with 2'b10 and expect exactly one `Dec`.
- **Glitch:** `Push`=2'b01 for 3 cycles, then 2'b11. Expect no command, and `State` returns to IDLE.
- **Auto-repeat:** `Push`=2'b01 for 40 cycles. Expect `Inc` pulses after edges 7, 23, 31 and 39, then none; `Rep`=1 from edge 23 until release.
- **Simultaneous buttons:** `Push`=2'b00 from idle gives no command. `Push`=2'b01 followed by 2'b00 after 10 cycles gives exactly one `Inc` and no `Dec` until both are released.
- **Release bounce:** after a press, `Push` toggles 11/01/11 with 2-cycle spacing. No extra `Inc` is issued, and IDLE is reached only after `DEB_CYC` stable high cycles.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// bcd_ctrl_pkg
// Shared constants for the push-button front end of the BCD counter:
//   state_t / S_*   : 3-bit FSM state encoding, also exported on the State port
//   DIR_UP / DIR_DN : value of the latched direction flop
//   BTN_UP / BTN_DN : bit positions of the buttons inside Push / sp
package bcd_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_QUAL   = 3'd1;
  localparam state_t S_FIRE   = 3'd2;
  localparam state_t S_HOLD   = 3'd3;
  localparam state_t S_REPEAT = 3'd4;
  localparam state_t S_REL    = 3'd5;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int BTN_UP = 1;
  localparam int BTN_DN = 0;

endpackage

// File: rtl/btn_sync.sv
// btn_sync
// Two-flop synchroniser for W asynchronous, active-low button lines.
// Both stages reset to 1 so a held reset reads as "no button pressed".
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   din   : raw asynchronous inputs
//   dout  : synchronised outputs, two clock edges behind din
module btn_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/bcd_push_ctrl.sv
// bcd_push_ctrl
// Turns the two active-low board buttons into single-cycle Inc/Dec commands
// for the 3-digit BCD counter, with debounce, up/down arbitration and
// auto-repeat while a button is held.
//   Clk   : clock, rising edge
//   Rst   : asynchronous active-low reset
//   Push  : raw buttons, active-low, Push[1]=UP, Push[0]=DOWN
//   Inc   : one-cycle increment command (registered)
//   Dec   : one-cycle decrement command (registered)
//   Rep   : high while auto-repeat is running (registered)
//   State : current FSM state, for debug / LEDs
// HOLD_CYC must be at least 2 and CW wide enough for the largest period.
module bcd_push_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 16,
  parameter int REP_CYC  = 8,
  parameter int CW       = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Push,
  output logic       Inc,
  output logic       Dec,
  output logic       Rep,
  output logic [2:0] State
);

  // Terminal timer values. The first repeat is measured from the command
  // edge, and the FIRE cycle plus the clearing edge use up two of those
  // cycles before HOLD starts counting, hence the -2.
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 2);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
  localparam logic [CW-1:0] TIMER_MAX = '1;

  logic [1:0]    sp;
  state_t        state, state_nx;
  logic [CW-1:0] timer, timer_nx, timer_sat;
  logic          dir, dir_nx;
  logic          cmd;
  logic          latched_low, other_low;

  btn_sync #(.W(2)) u_sync (
    .clk  (Clk),
    .rst_n(Rst),
    .din  (Push),
    .dout (sp)
  );

  assign latched_low = (dir == DIR_UP) ? ~sp[BTN_UP] : ~sp[BTN_DN];
  assign other_low   = (dir == DIR_UP) ? ~sp[BTN_DN] : ~sp[BTN_UP];
  assign timer_sat   = (timer == TIMER_MAX) ? timer : timer + CW'(1);
  assign State       = state;

  // Next-state logic. cmd marks the edge on which a command is issued; it is
  // only raised while the latched button is still seen low, so nothing can
  // fire once sp has gone high.
  always_comb begin
    state_nx = state;
    timer_nx = timer_sat;
    dir_nx   = dir;
    cmd      = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (sp == 2'b00) begin
          state_nx = S_REL;
        end else if (!sp[BTN_UP] && sp[BTN_DN]) begin
          dir_nx   = DIR_UP;
          state_nx = S_QUAL;
        end else if (sp[BTN_UP] && !sp[BTN_DN]) begin
          dir_nx   = DIR_DN;
          state_nx = S_QUAL;
        end
      end
      S_QUAL: begin
        if (!latched_low) begin
          timer_nx = '0;
          state_nx = S_IDLE;
        end else if (other_low) begin
          timer_nx = '0;
          state_nx = S_REL;
        end else if (timer >= DEB_LAST) begin
          cmd      = 1'b1;
          state_nx = S_FIRE;
        end
      end
      S_FIRE: begin
        timer_nx = '0;
        state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (!latched_low) begin
          timer_nx = '0;
          state_nx = S_REL;
        end else if (timer >= HOLD_LAST) begin
          cmd      = 1'b1;
          timer_nx = '0;
          state_nx = S_REPEAT;
        end
      end
      S_REPEAT: begin
        if (!latched_low) begin
          timer_nx = '0;
          state_nx = S_REL;
        end else if (timer >= REP_LAST) begin
          cmd      = 1'b1;
          timer_nx = '0;
        end
      end
      S_REL: begin
        // Any low bit restarts the release debounce.
        if (sp != 2'b11) begin
          timer_nx = '0;
        end else if (timer >= DEB_LAST) begin
          timer_nx = '0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        timer_nx = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, timer, direction and the registered outputs. dir only changes in
  // IDLE where cmd is never set, so the current dir is the one to decode.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
      timer <= '0;
      dir   <= DIR_UP;
      Inc   <= 1'b0;
      Dec   <= 1'b0;
      Rep   <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      dir   <= dir_nx;
      Inc   <= cmd & (dir == DIR_UP);
      Dec   <= cmd & (dir == DIR_DN);
      Rep   <= (state_nx == S_REPEAT);
    end
  end

endmodule

// File: tb/tb_bcd_push_ctrl.sv
// tb_bcd_push_ctrl
// Directed bench for bcd_push_ctrl at default parameters, 20 ns clock.
// Edge numbering: after push is changed (1 ns after a rising edge), the
// next rising edge is edge 1; outputs are logged 1 ns after each edge.
module tb_bcd_push_ctrl;
  import bcd_ctrl_pkg::*;

  localparam int LOGN = 96;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] push = 2'b01;
  logic       inc, dec, rep;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int ecount = 0;

  logic       inc_log   [1:LOGN];
  logic       dec_log   [1:LOGN];
  logic       rep_log   [1:LOGN];
  logic [2:0] state_log [1:LOGN];

  always #10 clk = ~clk;

  bcd_push_ctrl dut (
    .Clk  (clk),
    .Rst  (rst_n),
    .Push (push),
    .Inc  (inc),
    .Dec  (dec),
    .Rep  (rep),
    .State(state)
  );

  // Restart edge numbering for a new scenario.
  task clear_log;
    ecount = 0;
    for (int i = 1; i <= LOGN; i++) begin
      inc_log[i]   = 1'b0;
      dec_log[i]   = 1'b0;
      rep_log[i]   = 1'b0;
      state_log[i] = 3'd7;
    end
  endtask

  // Hold push at p for n edges, logging outputs after each edge.
  task drive(input logic [1:0] p, input int n);
    push = p;
    repeat (n) begin
      @(posedge clk);
      #1;
      ecount++;
      if (ecount <= LOGN) begin
        inc_log[ecount]   = inc;
        dec_log[ecount]   = dec;
        rep_log[ecount]   = rep;
        state_log[ecount] = state;
      end
    end
  endtask

  task test_reset;
    rst_n = 1'b0;
    push  = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state !== S_IDLE || inc !== 1'b0 || dec !== 1'b0 || rep !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: state=%0d inc=%b dec=%b rep=%b want state=0 all 0", state, inc, dec, rep);
    end
    rst_n = 1'b1;
    clear_log();
    drive(2'b11, 10);
    for (int e = 1; e <= 10; e++) begin
      checks++;
      if (inc_log[e] !== 1'b0 || dec_log[e] !== 1'b0 || rep_log[e] !== 1'b0 || state_log[e] !== S_IDLE) begin
        errors++;
        $display("[TB] FAIL reset_release edge %0d: inc=%b dec=%b rep=%b state=%0d want 0/0/0/IDLE",
                 e, inc_log[e], dec_log[e], rep_log[e], state_log[e]);
      end
    end
  endtask

  task test_single_press(input logic [1:0] p, input logic up);
    clear_log();
    drive(p, 10);
    drive(2'b11, 12);
    for (int e = 1; e <= 22; e++) begin
      checks++;
      if (inc_log[e] !== (up && e == 7) || dec_log[e] !== (!up && e == 7)) begin
        errors++;
        $display("[TB] FAIL single_press(%b) edge %0d: inc=%b dec=%b want pulse only at edge 7", p, e, inc_log[e], dec_log[e]);
      end
    end
    checks++;
    if (state_log[7] !== S_FIRE) begin
      errors++;
      $display("[TB] FAIL single_press_fire: state=%0d want %0d", state_log[7], S_FIRE);
    end
    checks++;
    if (state_log[22] !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL single_press_idle: state=%0d want %0d", state_log[22], S_IDLE);
    end
  endtask

  task test_glitch;
    clear_log();
    drive(2'b01, 3);
    drive(2'b11, 6);
    checks++;
    if (state_log[3] !== S_QUAL) begin
      errors++;
      $display("[TB] FAIL glitch_qual: state=%0d want %0d", state_log[3], S_QUAL);
    end
    checks++;
    if (state_log[6] !== S_IDLE || state_log[9] !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL glitch_idle: state6=%0d state9=%0d want %0d", state_log[6], state_log[9], S_IDLE);
    end
    for (int e = 1; e <= 9; e++) begin
      checks++;
      if (inc_log[e] !== 1'b0 || dec_log[e] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL glitch_cmd edge %0d: inc=%b dec=%b want 0", e, inc_log[e], dec_log[e]);
      end
    end
  endtask

  task test_auto_repeat;
    logic exp_inc, exp_rep;
    clear_log();
    drive(2'b01, 40);
    drive(2'b11, 12);
    for (int e = 1; e <= 52; e++) begin
      exp_inc = (e == 7) || (e == 23) || (e == 31) || (e == 39);
      exp_rep = (e >= 23) && (e <= 42);
      checks++;
      if (inc_log[e] !== exp_inc || dec_log[e] !== 1'b0 || rep_log[e] !== exp_rep) begin
        errors++;
        $display("[TB] FAIL auto_repeat edge %0d: inc=%b dec=%b rep=%b want inc=%b dec=0 rep=%b",
                 e, inc_log[e], dec_log[e], rep_log[e], exp_inc, exp_rep);
      end
    end
    checks++;
    if (state_log[43] !== S_REL || state_log[52] !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL auto_repeat_release: state43=%0d state52=%0d want %0d/%0d",
               state_log[43], state_log[52], S_REL, S_IDLE);
    end
  endtask

  task test_reset_mid;
    clear_log();
    drive(2'b01, 26);
    checks++;
    if (state_log[26] !== S_REPEAT || rep_log[26] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre: state=%0d rep=%b want %0d/1", state_log[26], rep_log[26], S_REPEAT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== S_IDLE || rep !== 1'b0 || inc !== 1'b0 || dec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: state=%0d rep=%b inc=%b dec=%b want IDLE and 0", state, rep, inc, dec);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    drive(2'b11, 12);
    for (int e = 1; e <= 12; e++) begin
      checks++;
      if (inc_log[e] !== 1'b0 || dec_log[e] !== 1'b0 || state_log[e] !== S_IDLE) begin
        errors++;
        $display("[TB] FAIL reset_mid_after edge %0d: inc=%b dec=%b state=%0d want 0/0/IDLE",
                 e, inc_log[e], dec_log[e], state_log[e]);
      end
    end
  endtask

  task test_simultaneous;
    // Both buttons from idle.
    clear_log();
    drive(2'b00, 6);
    drive(2'b11, 8);
    checks++;
    if (state_log[6] !== S_REL || state_log[12] !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL both_idle_state: state6=%0d state12=%0d want %0d/%0d", state_log[6], state_log[12], S_REL, S_IDLE);
    end
    for (int e = 1; e <= 14; e++) begin
      checks++;
      if (inc_log[e] !== 1'b0 || dec_log[e] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL both_idle_cmd edge %0d: inc=%b dec=%b want 0", e, inc_log[e], dec_log[e]);
      end
    end
    // UP held, then DOWN joins after the first command.
    clear_log();
    drive(2'b01, 10);
    drive(2'b00, 4);
    drive(2'b11, 12);
    for (int e = 1; e <= 26; e++) begin
      checks++;
      if (inc_log[e] !== (e == 7) || dec_log[e] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL up_then_both edge %0d: inc=%b dec=%b want inc only at 7", e, inc_log[e], dec_log[e]);
      end
    end
    checks++;
    if (state_log[26] !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL up_then_both_idle: state=%0d want %0d", state_log[26], S_IDLE);
    end
    // DOWN joins while UP is still qualifying: abandon without a command.
    clear_log();
    drive(2'b01, 2);
    drive(2'b00, 6);
    drive(2'b11, 10);
    checks++;
    if (state_log[4] !== S_QUAL || state_log[5] !== S_REL) begin
      errors++;
      $display("[TB] FAIL qual_other: state4=%0d state5=%0d want %0d/%0d", state_log[4], state_log[5], S_QUAL, S_REL);
    end
    for (int e = 1; e <= 18; e++) begin
      checks++;
      if (inc_log[e] !== 1'b0 || dec_log[e] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL qual_other_cmd edge %0d: inc=%b dec=%b want 0", e, inc_log[e], dec_log[e]);
      end
    end
  endtask

  task test_release_bounce;
    clear_log();
    drive(2'b01, 10);
    drive(2'b11, 2);
    drive(2'b01, 2);
    drive(2'b11, 12);
    for (int e = 1; e <= 26; e++) begin
      checks++;
      if (inc_log[e] !== (e == 7) || dec_log[e] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_cmd edge %0d: inc=%b dec=%b want inc only at 7", e, inc_log[e], dec_log[e]);
      end
    end
    checks++;
    if (state_log[13] !== S_REL || state_log[16] !== S_REL || state_log[19] !== S_REL) begin
      errors++;
      $display("[TB] FAIL bounce_rel: state13=%0d state16=%0d state19=%0d want %0d",
               state_log[13], state_log[16], state_log[19], S_REL);
    end
    checks++;
    if (state_log[20] !== S_IDLE) begin
      errors++;
      $display("[TB] FAIL bounce_idle: state20=%0d want %0d", state_log[20], S_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single_press(2'b01, 1'b1);
    test_single_press(2'b10, 1'b0);
    test_glitch();
    test_auto_repeat();
    test_reset_mid();
    test_simultaneous();
    test_release_bounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
